audio_filter_seq: RTL

AUDIO_FILTER_SEQ -- requirements
Module: audio_filter_seq

---
 rtl/audio_filter_seq_pkg.sv | 20 ++
 rtl/audio_filter_seq_if.sv | 30 +++
 rtl/audio_filter_seq_watchdog.sv | 34 +++
 rtl/audio_filter_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/audio_filter_seq_pkg.sv
// Shared types for the audio filter job sequencer: FSM states, the 3-bit job index and the stage limit.
package audio_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PUBLISH
    } seq_state_t;

    typedef logic [2:0] job_idx_t;

    // Job index layout is {stage, channel}, with the channel in the LSB (0 = left, 1 = right).
    function automatic job_idx_t make_job(input int unsigned stage, input logic ch);
        return {stage[1:0], ch};
    endfunction

endpackage

// File: rtl/audio_filter_seq_if.sv
// Handshake bus between the sequencer (master) and the shared filter MAC engine (slave).
interface audio_filter_seq_if;
    import audio_pkg::*;

    logic               mac_start;
    job_idx_t           mac_job;
    logic signed [15:0] mac_x;
    logic               mac_ready;
    logic               mac_done;
    logic signed [15:0] mac_y;

    modport master (
        output mac_start,
        output mac_job,
        output mac_x,
        input  mac_ready,
        input  mac_done,
        input  mac_y
    );

    modport slave (
        input  mac_start,
        input  mac_job,
        input  mac_x,
        output mac_ready,
        output mac_done,
        output mac_y
    );

endinterface

// File: rtl/audio_filter_seq_watchdog.sv
// WAIT-state watchdog: armed by a job start, disarmed by done, and expires after DONE_TIMEOUT silent cycles.
module audio_seq_watchdog #(
    parameter int DONE_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done,
    output logic expire
);

    logic [9:0] count;
    logic       armed;

    // The first cycle after start is wait cycle 1 (count 0), so expiry lands on the DONE_TIMEOUT-th cycle.
    assign expire = armed && !done && (count == 10'(DONE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            count <= '0;
        end else if (start) begin
            armed <= 1'b1;
            count <= '0;
        end else if (armed) begin
            if (done || expire) begin
                armed <= 1'b0;
            end else begin
                count <= count + 10'd1;
            end
        end
    end

endmodule

// File: rtl/audio_filter_seq.sv
// Sequences 2*NUM_STAGES cascaded filter jobs per stereo sample through one shared MAC engine.
// Optional watchdog on the engine handshake: define AUDIO_FILTER_SEQ_TIMEOUT_EN.
module audio_filter_seq
    import audio_pkg::*;
#(
    parameter int NUM_STAGES   = 2,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_ce,
    input  logic signed [15:0]        in_l,
    input  logic signed [15:0]        in_r,
    audio_filter_seq_if.master        mac,
    output logic signed [15:0]        out_l,
    output logic signed [15:0]        out_r,
    output logic                      out_valid,
    output logic                      overrun,
    output logic                      fault
);

    localparam job_idx_t LAST_JOB = make_job(NUM_STAGES - 1, 1'b1);

    seq_state_t         state;
    job_idx_t           job;
    job_idx_t           next_job;
    logic signed [15:0] x_reg;
    logic signed [15:0] next_x;
    logic signed [15:0] lat_l;
    logic signed [15:0] lat_r;
    logic signed [15:0] job_y;
    logic signed [15:0] results [2*MAX_STAGES];
    logic               expire;
    logic               job_end;

    // mac_start has to react to mac_ready in the same cycle, so it is the only output decoded from state.
    assign mac.mac_start = (state == ISSUE) && mac.mac_ready;
    assign mac.mac_job   = job;
    assign mac.mac_x     = x_reg;

    // A timed-out job keeps the result it produced for the previous sample.
    assign job_end = (state == WAIT) && (mac.mac_done || expire);
    assign job_y   = mac.mac_done ? mac.mac_y : results[job];

    always_comb begin
        next_job = job + 3'd1;
        if (next_job[2:1] == 2'd0) begin
            next_x = next_job[0] ? lat_r : lat_l;
        end else begin
            next_x = results[next_job - 3'd2];
        end
    end

`ifdef AUDIO_FILTER_SEQ_TIMEOUT_EN
    audio_seq_watchdog #(
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .start (mac.mac_start),
        .done  (mac.mac_done),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if ((state == WAIT) && expire) begin
            fault <= 1'b1;
        end
    end
`else
    // The timeout parameter only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = (DONE_TIMEOUT != 0);
    assign expire         = 1'b0;
    assign fault          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            job       <= '0;
            x_reg     <= '0;
            lat_l     <= '0;
            lat_r     <= '0;
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 2*MAX_STAGES; i++) begin
                results[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (sample_ce && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_ce) begin
                        lat_l <= in_l;
                        lat_r <= in_r;
                        job   <= '0;
                        x_reg <= in_l;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mac.mac_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (job_end) begin
                        results[job] <= job_y;
                        // Outputs are loaded on entry so they are already valid during the PUBLISH cycle.
                        if (job == LAST_JOB) begin
                            out_l     <= results[LAST_JOB - 3'd1];
                            out_r     <= job_y;
                            out_valid <= 1'b1;
                            state     <= PUBLISH;
                        end else begin
                            job   <= next_job;
                            x_reg <= next_x;
                            state <= ISSUE;
                        end
                    end
                end
                PUBLISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
